// File: rtl/multi_btn_debounce.sv
// -----------------------------------------------------------------------------
// multi_btn_debounce
// N-channel push-button conditioner for the front-panel input path. Each raw
// input is synchronised through two flops. It is then sampled on a shared
// prescaler tick and filtered so that the level only changes after STABLE_CNT
// consecutive disagreeing samples. Single-cycle press, release and
// auto-repeat strobes are derived from the filtered level.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   i_btn      raw asynchronous button inputs, active-high
//   o_level    debounced level per channel
//   o_press    one-clk pulse on debounced 0->1
//   o_release  one-clk pulse on debounced 1->0
//   o_repeat   one-clk pulse per auto-repeat while held (0 when REPEAT_EN=0)
// -----------------------------------------------------------------------------
module multi_btn_debounce #(
    parameter int N_BTN        = 5,
    parameter int SAMPLE_DIV   = 100,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_EN    = 1,
    parameter int HOLD_TICKS   = 50000,
    parameter int REPEAT_TICKS = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int DIV_W    = $clog2(SAMPLE_DIV);
    localparam int CNT_W    = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] RPT_END  = HOLD_W'(REPEAT_TICKS);

    logic [N_BTN-1:0]  sync1_q, sync1_d;
    logic [N_BTN-1:0]  sync2_q, sync2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic [CNT_W-1:0]  stab_q [N_BTN];
    logic [CNT_W-1:0]  stab_d [N_BTN];
    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
    logic [N_BTN-1:0]  phase_q, phase_d;
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  press_q, press_d;
    logic [N_BTN-1:0]  release_q, release_d;
    logic [N_BTN-1:0]  repeat_q, repeat_d;

    // Synchroniser and shared prescaler.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + DIV_W'(1);
    end

    // Per-channel stability filter and auto-repeat.
    always_comb begin
        stab_d    = stab_q;
        hold_d    = hold_q;
        phase_d   = phase_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == CNT_LAST) begin
                    stab_d[i]    = '0;
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + CNT_W'(1);
                end
            end

            // The hold counter only runs on ticks where the level was already
            // high and stays high; the press tick clears it and the releasing
            // tick clears it without ever raising a repeat.
            if ((level_d[i] != level_q[i]) || !level_q[i]) begin
                hold_d[i]  = '0;
                phase_d[i] = 1'b0;
            end else if (tick) begin
                if ((hold_q[i] + HOLD_W'(1)) == (phase_q[i] ? RPT_END : HOLD_END)) begin
                    hold_d[i]   = '0;
                    phase_d[i]  = 1'b1;
                    repeat_d[i] = (REPEAT_EN != 0);
                end else begin
                    hold_d[i] = hold_q[i] + HOLD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stab_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                stab_q[i] <= stab_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;

endmodule

// File: tb/tb_multi_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_btn_debounce
// Directed bench for multi_btn_debounce with N_BTN=2, SAMPLE_DIV=4,
// STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2. Stimulus pushes the expected
// strobe vectors and their cycle windows into a queue. A negedge monitor pops
// an entry whenever the DUT raises any strobe and compares it with that entry.
// A second instance with REPEAT_EN=0 has its own queue and monitor.
// -----------------------------------------------------------------------------
module tb_multi_btn_debounce;

    localparam int N      = 2;
    localparam int D      = 4;
    localparam int S      = 3;
    localparam int H      = 5;
    localparam int R      = 2;
    localparam int LAT_LO = 2 + (S - 1) * D + 1;   // 11
    localparam int LAT_HI = 2 + S * D + 1;         // 15
    localparam int T_HOLD = H * D;                 // 20
    localparam int T_RPT  = R * D;                 // 8

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_btn, i_btn_nr;
    logic [N-1:0] o_level, o_press, o_release, o_repeat;
    logic [N-1:0] n_level, n_press, n_release, n_repeat;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int last_evt_cyc = 0;

    typedef struct {
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
        int           lo;
        int           hi;
    } exp_t;

    exp_t q[$];
    exp_t q_nr[$];
    exp_t e_m, e_n;

    multi_btn_debounce #(
        .N_BTN(N), .SAMPLE_DIV(D), .STABLE_CNT(S),
        .REPEAT_EN(1), .HOLD_TICKS(H), .REPEAT_TICKS(R)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(o_level), .o_press(o_press),
        .o_release(o_release), .o_repeat(o_repeat)
    );

    multi_btn_debounce #(
        .N_BTN(N), .SAMPLE_DIV(D), .STABLE_CNT(S),
        .REPEAT_EN(0), .HOLD_TICKS(H), .REPEAT_TICKS(R)
    ) dut_nr (
        .clk(clk), .rst(rst), .i_btn(i_btn_nr),
        .o_level(n_level), .o_press(n_press),
        .o_release(n_release), .o_repeat(n_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((o_press | o_release | o_repeat) != 2'b00) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b repeat=%b required none",
                         cyc, o_press, o_release, o_repeat);
            end else begin
                e_m = q.pop_front();
                checks++;
                if ({o_press, o_release, o_repeat} !== {e_m.press, e_m.rel, e_m.rep}) begin
                    failures++;
                    $display("FAIL strobe_value cyc=%0d actual p/r/rp=%b/%b/%b required %b/%b/%b",
                             cyc, o_press, o_release, o_repeat, e_m.press, e_m.rel, e_m.rep);
                end
                checks++;
                if (cyc < e_m.lo || cyc > e_m.hi) begin
                    failures++;
                    $display("FAIL strobe_time actual cyc=%0d required %0d..%0d", cyc, e_m.lo, e_m.hi);
                end
                last_evt_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if ((n_press | n_release | n_repeat) != 2'b00) begin
            if (q_nr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL nr_unexpected_strobe cyc=%0d press=%b release=%b repeat=%b required none",
                         cyc, n_press, n_release, n_repeat);
            end else begin
                e_n = q_nr.pop_front();
                checks++;
                if ({n_press, n_release, n_repeat} !== {e_n.press, e_n.rel, e_n.rep}) begin
                    failures++;
                    $display("FAIL nr_strobe_value cyc=%0d actual p/r/rp=%b/%b/%b required %b/%b/%b",
                             cyc, n_press, n_release, n_repeat, e_n.press, e_n.rel, e_n.rep);
                end
                checks++;
                if (cyc < e_n.lo || cyc > e_n.hi) begin
                    failures++;
                    $display("FAIL nr_strobe_time actual cyc=%0d required %0d..%0d", cyc, e_n.lo, e_n.hi);
                end
            end
        end
    end

    task automatic push(input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] rp,
                        input int lo, input int hi);
        exp_t e;
        e.press = p; e.rel = r; e.rep = rp; e.lo = lo; e.hi = hi;
        q.push_back(e);
    endtask

    task automatic push_nr(input logic [N-1:0] p, input logic [N-1:0] r, input int lo, input int hi);
        exp_t e;
        e.press = p; e.rel = r; e.rep = '0; e.lo = lo; e.hi = hi;
        q_nr.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout cyc=%0d actual pending=%0d required 0", name, cyc, q.size());
            q.delete();
        end
    endtask

    task automatic wait_drain_nr(input string name, input int budget);
        int n = 0;
        while (q_nr.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q_nr.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout cyc=%0d actual pending=%0d required 0", name, cyc, q_nr.size());
            q_nr.delete();
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r, c, p;

        // Reset with both buttons held.
        rst      = 1'b1;
        i_btn    = 2'b11;
        i_btn_nr = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_hold", {o_level, o_press, o_release, o_repeat}, 8'h00);
        end
        rst = 1'b0;
        r = cyc;
        push(2'b11, 2'b00, 2'b00, r + LAT_LO, r + LAT_HI);
        @(negedge clk);
        chk("reset_release", {o_level, o_press, o_release, o_repeat}, 8'h00);
        wait_drain("reset_press", 30);
        chk("reset_level", {6'b0, o_level}, 8'h03);
        c = cyc;
        i_btn = 2'b00;
        push(2'b00, 2'b11, 2'b00, c + LAT_LO, c + LAT_HI);
        wait_drain("reset_rel", 30);
        repeat (30) @(negedge clk);
        chk("idle_level", {6'b0, o_level}, 8'h00);

        // Clean press / hold / release on ch0; release lands where a repeat is due.
        c = cyc;
        i_btn = 2'b01;
        push(2'b01, 2'b00, 2'b00, c + LAT_LO, c + LAT_HI);
        wait_drain("ch0_press", 30);
        p = last_evt_cyc;
        chk("ch0_level_hi", {6'b0, o_level}, 8'h01);
        push(2'b00, 2'b00, 2'b01, p + T_HOLD, p + T_HOLD);
        push(2'b00, 2'b00, 2'b01, p + T_HOLD + T_RPT, p + T_HOLD + T_RPT);
        push(2'b00, 2'b00, 2'b01, p + T_HOLD + 2 * T_RPT, p + T_HOLD + 2 * T_RPT);
        push(2'b00, 2'b01, 2'b00, p + T_HOLD + 3 * T_RPT, p + T_HOLD + 3 * T_RPT);
        wait_until(p + 33);
        i_btn = 2'b00;
        wait_drain("ch0_hold", 40);
        repeat (30) @(negedge clk);
        chk("ch0_level_lo", {6'b0, o_level}, 8'h00);

        // Bounce: 5-cycle pulses never build three agreeing ticks.
        for (int t = 0; t < 12; t++) begin
            i_btn[0] = ~i_btn[0];
            repeat (5) @(negedge clk);
            chk("bounce_level", {6'b0, o_level}, 8'h00);
        end
        i_btn = 2'b00;
        repeat (30) @(negedge clk);
        chk("bounce_final", {6'b0, o_level}, 8'h00);

        // Simultaneous press, then release ch1 only while ch0 keeps repeating.
        c = cyc;
        i_btn = 2'b11;
        push(2'b11, 2'b00, 2'b00, c + LAT_LO, c + LAT_HI);
        wait_drain("both_press", 30);
        p = last_evt_cyc;
        chk("both_level", {6'b0, o_level}, 8'h03);
        push(2'b00, 2'b00, 2'b11, p + 20, p + 20);
        push(2'b00, 2'b00, 2'b11, p + 28, p + 28);
        push(2'b00, 2'b10, 2'b00, p + 32, p + 32);
        push(2'b00, 2'b00, 2'b01, p + 36, p + 36);
        push(2'b00, 2'b00, 2'b01, p + 44, p + 44);
        wait_until(p + 21);
        i_btn = 2'b01;
        wait_until(p + 46);
        wait_drain("ch1_release", 5);
        chk("ch0_still_hi", {6'b0, o_level}, 8'h01);

        // Reset mid-hold: level drops silently and re-presses.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_level", {6'b0, o_level}, 8'h00);
        r = cyc;
        push(2'b01, 2'b00, 2'b00, r + LAT_LO, r + LAT_HI);
        wait_drain("midrst_press", 30);
        p = last_evt_cyc;
        push(2'b00, 2'b00, 2'b01, p + 20, p + 20);
        push(2'b00, 2'b00, 2'b01, p + 28, p + 28);
        push(2'b00, 2'b00, 2'b01, p + 36, p + 36);
        push(2'b00, 2'b01, 2'b00, p + 44, p + 44);
        wait_until(p + 33);
        i_btn = 2'b00;
        wait_drain("midrst_hold", 40);
        chk("midrst_level_lo", {6'b0, o_level}, 8'h00);

        // REPEAT_EN=0 instance: press and release only.
        c = cyc;
        i_btn_nr = 2'b01;
        push_nr(2'b01, 2'b00, c + LAT_LO, c + LAT_HI);
        wait_drain_nr("nr_press", 30);
        repeat (200) @(negedge clk);
        chk("nr_level_hi", {6'b0, n_level}, 8'h01);
        chk("nr_repeat", {6'b0, n_repeat}, 8'h00);
        c = cyc;
        i_btn_nr = 2'b00;
        push_nr(2'b00, 2'b01, c + LAT_LO, c + LAT_HI);
        wait_drain_nr("nr_release", 30);
        repeat (10) @(negedge clk);
        chk("nr_level_lo", {6'b0, n_level}, 8'h00);

        wait_drain("final", 1);
        wait_drain_nr("final_nr", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
